// File: rtl/fetch_predecode_pkg.sv
// Shared constants and types for the fetch/predecode stage: opcodes,
// immediate selector encodings, FSM states and the FIFO entry layout.
package fetch_predecode_pkg;

    localparam logic [31:0] RESET_PC_DEFAULT = 32'h0000_0000;

    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_IMM    = 7'b0010011;
    localparam logic [6:0] OP_JALR   = 7'b1100111;
    localparam logic [6:0] OP_SYSTEM = 7'b1110011;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;
    localparam logic [6:0] OP_LUI    = 7'b0110111;
    localparam logic [6:0] OP_AUIPC  = 7'b0010111;
    localparam logic [6:0] OP_JAL    = 7'b1101111;
    localparam logic [6:0] OP_OP     = 7'b0110011;

    typedef enum logic [2:0] {
        IMM_I = 3'b000,
        IMM_S = 3'b001,
        IMM_B = 3'b010,
        IMM_U = 3'b011,
        IMM_J = 3'b100
    } imm_src_t;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_FETCH = 2'd1,
        ST_STALL = 2'd2,
        ST_DRAIN = 2'd3
    } fetch_state_t;

    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] inst;
    } fetch_entry_t;

endpackage

// File: rtl/fetch_predecode_if.sv
// Instruction memory request bus plus the predecoded output towards the
// immediate generator. master = fetch stage, slave = memory/decoder side.
interface fetch_predecode_if;
    // Both channels use valid/ready: a transfer happens on the rising edge where
    // the source's valid (imem_req / dec_valid) and the sink's ready are both 1;
    // the source holds its payload stable while valid is high and ready is low.
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_ready;
    logic [31:0] imem_rdata;

    logic        dec_valid;
    logic        dec_ready;
    logic [31:0] dec_pc;
    logic [31:0] dec_inst;
    logic [24:0] imm_inst;
    logic [2:0]  imm_src;
    logic        dec_illegal;

    modport master (
        output imem_req, imem_addr, dec_valid, dec_pc, dec_inst,
               imm_inst, imm_src, dec_illegal,
        input  imem_ready, imem_rdata, dec_ready
    );

    modport slave (
        input  imem_req, imem_addr, dec_valid, dec_pc, dec_inst,
               imm_inst, imm_src, dec_illegal,
        output imem_ready, imem_rdata, dec_ready
    );
endinterface

// File: rtl/fetch_predecode_fifo.sv
// fetch_fifo: synchronous show-ahead FIFO of {pc, inst} entries with flush.
// DEPTH must be a power of two so the pointers wrap without compare logic.
module fetch_fifo #(
    parameter int DEPTH = 2,
    parameter int WIDTH = 64
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       flush,
    input  logic                       push,
    input  logic                       pop,
    input  logic [WIDTH-1:0]           wdata,
    output logic [WIDTH-1:0]           rdata,
    output logic                       full,
    output logic                       empty,
    output logic [$clog2(DEPTH):0]     count
);
    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;
    localparam logic [CW-1:0] FULL_CNT = CW'(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr;
    logic [AW-1:0]    rd_ptr;
    logic             do_push;
    logic             do_pop;

    assign full    = (count == FULL_CNT);
    assign empty   = (count == '0);
    // A push into a full FIFO is legal when the head leaves in the same cycle.
    assign do_push = push && (!full || pop);
    assign do_pop  = pop && !empty;
    assign rdata   = mem[rd_ptr];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else if (flush) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + 1'b1;
            if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
            case ({do_push, do_pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (do_push && !flush) mem[wr_ptr] <= wdata;
    end
endmodule

// File: rtl/fetch_predecode.sv
// Fetch + predecode stage: PC/fetch FSM, instruction FIFO, opcode predecode.
// Optional FETCH_PERF_CNT_EN adds perf_fetched / perf_stall counters.
module fetch_predecode
    import fetch_predecode_pkg::*;
#(
    parameter logic [31:0] RESET_PC   = RESET_PC_DEFAULT,
    parameter int          FIFO_DEPTH = 2
) (
    input  logic                clk,
    input  logic                rst_n,
    fetch_predecode_if.master   bus,
    input  logic                redirect_valid,
    input  logic [31:0]         redirect_pc,
    output fetch_state_t        dbg_state
`ifdef FETCH_PERF_CNT_EN
    ,
    output logic [31:0]         perf_fetched,
    output logic [31:0]         perf_stall
`endif
);
    localparam int CW = $clog2(FIFO_DEPTH) + 1;
    localparam logic [CW-1:0] LAST_SLOT = CW'(FIFO_DEPTH - 1);

    fetch_state_t  state_q, state_d;
    logic [31:0]   pc_q, pc_d;
    logic [31:0]   drain_addr_q, drain_addr_d;

    logic          handshake;
    logic          push;
    logic          pop;
    logic          fifo_full;
    logic          fifo_empty;
    logic [CW-1:0] fifo_count;
    fetch_entry_t  wr_entry;
    fetch_entry_t  head;
    logic          valid;

    assign bus.imem_req  = (state_q == ST_FETCH) || (state_q == ST_DRAIN);
    // While draining, the abandoned request must stay on the bus untouched.
    assign bus.imem_addr = (state_q == ST_DRAIN) ? drain_addr_q : pc_q;
    assign handshake     = bus.imem_req && bus.imem_ready;

    assign valid    = !fifo_empty;
    assign push     = handshake && (state_q == ST_FETCH) && !redirect_valid
                      && (!fifo_full || pop);
    assign pop      = valid && bus.dec_ready && !redirect_valid;
    assign wr_entry = '{pc: pc_q, inst: bus.imem_rdata};
    assign dbg_state = state_q;

    fetch_fifo #(
        .DEPTH (FIFO_DEPTH),
        .WIDTH ($bits(fetch_entry_t))
    ) u_fifo (
        .clk   (clk),
        .rst_n (rst_n),
        .flush (redirect_valid),
        .push  (push),
        .pop   (pop),
        .wdata (wr_entry),
        .rdata (head),
        .full  (fifo_full),
        .empty (fifo_empty),
        .count (fifo_count)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= ST_IDLE;
            pc_q         <= RESET_PC;
            drain_addr_q <= RESET_PC;
        end else begin
            state_q      <= state_d;
            pc_q         <= pc_d;
            drain_addr_q <= drain_addr_d;
        end
    end

    always_comb begin
        state_d      = state_q;
        pc_d         = pc_q;
        drain_addr_d = drain_addr_q;

        case (state_q)
            ST_IDLE:  state_d = ST_FETCH;
            ST_FETCH: begin
                if (push) begin
                    pc_d = pc_q + 32'd4;
                    if (!pop && fifo_count == LAST_SLOT) state_d = ST_STALL;
                end
            end
            ST_STALL: if (pop) state_d = ST_FETCH;
            ST_DRAIN: if (bus.imem_ready) state_d = ST_FETCH;
            default:  state_d = ST_IDLE;
        endcase

        // Redirect overrides everything above; an unanswered request forces a drain.
        if (redirect_valid) begin
            pc_d = redirect_pc & 32'hFFFF_FFFC;
            if (bus.imem_req && !bus.imem_ready) begin
                state_d = ST_DRAIN;
                if (state_q == ST_FETCH) drain_addr_d = pc_q;
            end else begin
                state_d = ST_FETCH;
            end
        end
    end

    imm_src_t    src;
    logic [24:0] imm;
    logic        illegal;
    logic [31:0] inst;

    assign inst = head.inst;

    always_comb begin
        src     = IMM_I;
        imm     = '0;
        illegal = 1'b0;
        if (valid) begin
            case (inst[6:0])
                OP_LOAD, OP_IMM, OP_JALR, OP_SYSTEM: imm = inst[31:7];
                OP_STORE: begin
                    src = IMM_S;
                    imm = {13'b0, inst[31:25], inst[11:7]};
                end
                OP_BRANCH: begin
                    src = IMM_B;
                    imm = {12'b0, inst[31], inst[7], inst[30:25], inst[11:8], 1'b0};
                end
                OP_LUI, OP_AUIPC: begin
                    src = IMM_U;
                    imm = {5'b0, inst[31:12]};
                end
                OP_JAL: begin
                    src = IMM_J;
                    imm = {4'b0, inst[31], inst[19:12], inst[20], inst[30:21], 1'b0};
                end
                OP_OP:   imm = '0;
                default: illegal = 1'b1;
            endcase
        end
    end

    assign bus.dec_valid   = valid;
    assign bus.dec_pc      = valid ? head.pc : 32'h0;
    assign bus.dec_inst    = valid ? inst : 32'h0;
    assign bus.imm_inst    = imm;
    assign bus.imm_src     = src;
    assign bus.dec_illegal = illegal;

`ifdef FETCH_PERF_CNT_EN
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            perf_fetched <= 32'h0;
            perf_stall   <= 32'h0;
        end else begin
            if (push) perf_fetched <= perf_fetched + 32'd1;
            if (state_q == ST_STALL || state_q == ST_DRAIN)
                perf_stall <= perf_stall + 32'd1;
        end
    end
`endif
endmodule

// File: tb/tb_fetch_predecode.sv
// Directed bench for fetch_predecode: cycle-by-cycle bus checks in the main
// process plus a decoupled monitor that scores every consumed dec_* entry.
module tb_fetch_predecode;
    import fetch_predecode_pkg::*;

    logic         clk = 1'b0;
    logic         rst_n;
    logic         redirect_valid;
    logic [31:0]  redirect_pc;
    fetch_state_t dbg_state;
`ifdef FETCH_PERF_CNT_EN
    logic [31:0]  perf_fetched;
    logic [31:0]  perf_stall;
`endif

    fetch_predecode_if bus ();

    fetch_predecode #(
        .RESET_PC   (32'h0000_0000),
        .FIFO_DEPTH (2)
    ) dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .bus            (bus.master),
        .redirect_valid (redirect_valid),
        .redirect_pc    (redirect_pc),
        .dbg_state      (dbg_state)
`ifdef FETCH_PERF_CNT_EN
        ,
        .perf_fetched   (perf_fetched),
        .perf_stall     (perf_stall)
`endif
    );

    always #5 clk = ~clk;

    // Memory image (indexed by addr[5:2]) with hand-computed predecode results.
    logic [31:0] word_tab [16];
    logic [2:0]  src_tab  [16];
    logic [24:0] imm_tab  [16];
    logic        ill_tab  [16];

    assign bus.imem_rdata = word_tab[bus.imem_addr[5:2]];

    int tests = 0;
    int fails = 0;
    int hs_count = 0;
    logic [92:0] exp_q [$];
    logic [92:0] exp_e;
    logic [92:0] act_e;

    function automatic logic [92:0] mk(input logic [31:0] pc);
        return {pc, word_tab[pc[5:2]], src_tab[pc[5:2]], imm_tab[pc[5:2]], ill_tab[pc[5:2]]};
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %h required %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic smp();
        @(negedge clk);
    endtask

    always @(negedge clk) begin
        if (rst_n && bus.imem_req && bus.imem_ready) hs_count++;
    end

    // Monitor: every entry the decoder actually takes must match the queue head.
    always @(negedge clk) begin
        if (rst_n && bus.dec_valid && bus.dec_ready && !redirect_valid) begin
            act_e = {bus.dec_pc, bus.dec_inst, bus.imm_src, bus.imm_inst, bus.dec_illegal};
            tests++;
            if (exp_q.size() == 0) begin
                fails++;
                $display("FAIL dec_unexpected: got pc %h inst %h, required no entry", bus.dec_pc, bus.dec_inst);
            end else begin
                exp_e = exp_q.pop_front();
                if (act_e !== exp_e) begin
                    fails++;
                    $display("FAIL dec_entry: got pc %h inst %h src %b imm %h ill %b required pc %h inst %h src %b imm %h ill %b",
                             act_e[92:61], act_e[60:29], act_e[28:26], act_e[25:1], act_e[0],
                             exp_e[92:61], exp_e[60:29], exp_e[28:26], exp_e[25:1], exp_e[0]);
                end
            end
        end
    end

    int base;

    initial begin
        for (int i = 0; i < 16; i++) begin
            word_tab[i] = 32'h0000_0013;
            src_tab[i]  = 3'b000;
            imm_tab[i]  = 25'h0;
            ill_tab[i]  = 1'b0;
        end
        word_tab[0]  = 32'h0050_0093; imm_tab[0] = 25'h000A001;
        word_tab[1]  = 32'hFE00_08E3; src_tab[1] = 3'b010; imm_tab[1] = 25'h0001FF0;
        word_tab[2]  = 32'h1234_52B7; src_tab[2] = 3'b011; imm_tab[2] = 25'h0012345;
        word_tab[3]  = 32'h0011_2623; src_tab[3] = 3'b001; imm_tab[3] = 25'h000000C;
        word_tab[4]  = 32'h0000_006F; src_tab[4] = 3'b100; imm_tab[4] = 25'h0;
        word_tab[5]  = 32'hFFFF_FFFF; ill_tab[5] = 1'b1;
        word_tab[6]  = 32'h0020_81B3;
        word_tab[15] = 32'h0000_1017; src_tab[15] = 3'b011; imm_tab[15] = 25'h0000001;

        for (int a = 0; a < 7; a++) exp_q.push_back(mk(32'(a * 4)));
        exp_q.push_back(mk(32'h40));
        exp_q.push_back(mk(32'h44));
        exp_q.push_back(mk(32'h48));
        exp_q.push_back(mk(32'h100));
        exp_q.push_back(mk(32'hFFFF_FFFC));
        exp_q.push_back(mk(32'h0));

        rst_n = 1'b0;
        redirect_valid = 1'b0;
        redirect_pc = 32'h0;
        bus.imem_ready = 1'b1;
        bus.dec_ready = 1'b1;
        repeat (3) @(posedge clk);
        smp();
        chk("rst_imem_req", bus.imem_req, 0);
        chk("rst_imem_addr", bus.imem_addr, 32'h0);
        chk("rst_dec_valid", bus.dec_valid, 0);
        chk("rst_dec_pc", bus.dec_pc, 0);
        chk("rst_dec_inst", bus.dec_inst, 0);
        chk("rst_imm_inst", bus.imm_inst, 0);
        chk("rst_imm_src", bus.imm_src, 0);
        chk("rst_dec_illegal", bus.dec_illegal, 0);
        chk("rst_state", dbg_state, ST_IDLE);

        cyc(); rst_n = 1'b1; smp();
        chk("c1_imem_req", bus.imem_req, 0);
        chk("c1_dec_valid", bus.dec_valid, 0);
        cyc(); smp();
        chk("c2_imem_req", bus.imem_req, 1);
        chk("c2_imem_addr", bus.imem_addr, 32'h0);
        chk("c2_dec_valid", bus.dec_valid, 0);
        for (int k = 3; k <= 9; k++) begin
            cyc(); smp();
            chk("stream_dec_valid", bus.dec_valid, 1);
            chk("stream_dec_pc", bus.dec_pc, 32'(4 * (k - 3)));
        end

        // Redirect coinciding with a handshake and a pop.
        cyc(); redirect_valid = 1'b1; redirect_pc = 32'h40; smp();
        chk("c10_dec_pc", bus.dec_pc, 32'h1C);
        chk("c10_imem_addr", bus.imem_addr, 32'h20);
        cyc(); redirect_valid = 1'b0; bus.dec_ready = 1'b0; base = hs_count; smp();
        chk("redir_flush_valid", bus.dec_valid, 0);
        chk("redir_imem_addr", bus.imem_addr, 32'h40);
        chk("redir_imem_req", bus.imem_req, 1);
        cyc(); smp();
        chk("bp_dec_pc", bus.dec_pc, 32'h40);
        chk("bp_imem_addr", bus.imem_addr, 32'h44);
        for (int k = 0; k < 3; k++) begin
            cyc(); smp();
            chk("bp_imem_req_low", bus.imem_req, 0);
            chk("bp_state", dbg_state, ST_STALL);
        end
        cyc();
        chk("bp_handshakes", 32'(hs_count - base), 2);
        base = hs_count; bus.dec_ready = 1'b1; smp();
        chk("pop1_dec_pc", bus.dec_pc, 32'h40);
        cyc(); bus.dec_ready = 1'b0; smp();
        chk("pop1_imem_req", bus.imem_req, 1);
        chk("pop1_imem_addr", bus.imem_addr, 32'h48);
        cyc(); smp();
        chk("pop1_req_low", bus.imem_req, 0);
        cyc();
        chk("pop1_handshakes", 32'(hs_count - base), 1);

        // Drain: empty the FIFO with memory stalled, then redirect mid-request.
        bus.dec_ready = 1'b1; bus.imem_ready = 1'b0; smp();
        chk("drain_pre_pc0", bus.dec_pc, 32'h44);
        cyc(); smp();
        chk("drain_pre_pc1", bus.dec_pc, 32'h48);
        chk("drain_pre_addr", bus.imem_addr, 32'h4C);
        cyc(); redirect_valid = 1'b1; redirect_pc = 32'h103; smp();
        chk("drain_c0_valid", bus.dec_valid, 0);
        chk("drain_c0_addr", bus.imem_addr, 32'h4C);
        cyc(); redirect_valid = 1'b0; smp();
        chk("drain_state", dbg_state, ST_DRAIN);
        chk("drain_c1_req", bus.imem_req, 1);
        chk("drain_c1_addr", bus.imem_addr, 32'h4C);
        cyc(); smp();
        chk("drain_c2_addr", bus.imem_addr, 32'h4C);
        chk("drain_c2_valid", bus.dec_valid, 0);
        cyc(); bus.imem_ready = 1'b1; smp();
        chk("drain_c3_addr", bus.imem_addr, 32'h4C);
        chk("drain_c3_valid", bus.dec_valid, 0);
        cyc(); smp();
        chk("drain_new_req", bus.imem_req, 1);
        chk("drain_new_addr", bus.imem_addr, 32'h100);
        chk("drain_discarded", bus.dec_valid, 0);
        cyc(); smp();
        chk("drain_new_pc", bus.dec_pc, 32'h100);

        // Redirect to an unaligned top-of-memory target; PC must wrap to 0.
        cyc(); redirect_valid = 1'b1; redirect_pc = 32'hFFFF_FFFF; smp();
        chk("wrap_pre_pc", bus.dec_pc, 32'h104);
        cyc(); redirect_valid = 1'b0; smp();
        chk("wrap_valid", bus.dec_valid, 0);
        chk("wrap_addr0", bus.imem_addr, 32'hFFFF_FFFC);
        cyc(); smp();
        chk("wrap_pc0", bus.dec_pc, 32'hFFFF_FFFC);
        chk("wrap_addr1", bus.imem_addr, 32'h0);
        cyc(); smp();
        chk("wrap_pc1", bus.dec_pc, 32'h0);
        cyc(); bus.dec_ready = 1'b0; smp();
        chk("wrap_pc2", bus.dec_pc, 32'h4);
        repeat (3) cyc();
        smp();
        chk("exp_q_drained", 32'(exp_q.size()), 0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
